// File: rtl/prbs4_checker.sv
// prbs4_checker: self-synchronising serial checker for the x^4+x^3+1 PRBS-4 stream.
// Reports lock, one-cycle error pulses and a saturating error count.
`default_nettype none

module prbs4_checker #(
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic             data_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_TGT = 4'(LOSS_CNT);
  localparam logic [2:0] FILL_MAX = 3'd4;

  state_t           state_q, state_d;
  logic [3:0]       h_q, h_d;
  logic [2:0]       fill_q, fill_d;
  logic [3:0]       match_q, match_d;
  logic [3:0]       miss_q, miss_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic pred;
  logic mism;

  assign pred = h_q[3] ^ h_q[2];
  assign mism = data_i ^ pred;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    fill_d  = fill_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    if (valid_i) begin
      if (state_q == SEARCH) begin
        h_d = {h_q[2:0], data_i};
        if (fill_q != FILL_MAX) begin
          fill_d = fill_q + 3'd1;
        end else if (!mism && (h_q != 4'd0)) begin
          match_d = match_q + 4'd1;
          if (match_q + 4'd1 == LOCK_TGT) begin
            state_d = LOCKED;
          end
        end else begin
          // All-zero history is the LFSR lock-up state and must never count.
          match_d = 4'd0;
        end
      end else begin
        // Once locked the local LFSR free-runs so single bit errors do not desync it.
        h_d = {h_q[2:0], pred};
        if (mism) begin
          err_d  = 1'b1;
          miss_d = miss_q + 4'd1;
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (miss_q + 4'd1 == LOSS_TGT) begin
            state_d = SEARCH;
            fill_d  = 3'd0;
            match_d = 4'd0;
            miss_d  = 4'd0;
          end
        end else begin
          miss_d = 4'd0;
        end
      end
    end

    if (clear_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SEARCH;
      h_q     <= 4'd0;
      fill_q  <= 3'd0;
      match_q <= 4'd0;
      miss_q  <= 4'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign locked_o  = (state_q == LOCKED);
  assign err_o     = err_q;
  assign err_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_prbs4_checker.sv
// tb_prbs4_checker: directed self-checking bench for prbs4_checker (CNT_W=4 to reach saturation).
`default_nettype none

module tb_prbs4_checker;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             valid_i;
  logic             data_i;
  logic             clear_i;
  logic             locked_o;
  logic             err_o;
  logic [CNT_W-1:0] err_cnt_o;

  int         n_checks;
  int         n_fail;
  logic [3:0] g;

  prbs4_checker #(
    .LOCK_CNT(8),
    .LOSS_CNT(3),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_i  (valid_i),
    .data_i   (data_i),
    .clear_i  (clear_i),
    .locked_o (locked_o),
    .err_o    (err_o),
    .err_cnt_o(err_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic l, input logic e, input logic [31:0] c);
    check({tag, ".locked"}, 32'(locked_o), 32'(l));
    check({tag, ".err"}, 32'(err_o), 32'(e));
    check({tag, ".cnt"}, 32'(err_cnt_o), c);
  endtask

  // Apply one cycle of input, then sample 1 ns after the edge.
  task automatic send(input logic v, input logic d);
    valid_i = v;
    data_i  = d;
    @(posedge clk);
    #1;
  endtask

  // Reference generator: next bit = h[3]^h[2], optional inversion on the wire.
  task automatic gen_bit(input logic flip);
    logic b;
    b = g[3] ^ g[2];
    g = {g[2:0], b};
    send(1'b1, b ^ flip);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    g        = 4'b0001;
    reset    = 1'b0;
    valid_i  = 1'b0;
    data_i   = 1'b0;
    clear_i  = 1'b0;
    #1;
    check_out("reset", 1'b0, 1'b0, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      send(1'b0, i[0]);
      check_out("idle", 1'b0, 1'b0, 0);
    end

    // Clean stream: lock exactly on the 12th valid bit, no errors over 100 bits.
    for (int i = 1; i <= 100; i++) begin
      gen_bit(1'b0);
      check("lock_seq", 32'(locked_o), 32'(i >= 12));
      check("lock_seq.err", 32'(err_o), 0);
    end
    check("clean.cnt", 32'(err_cnt_o), 0);

    // Single inverted bit while locked, then an idle cycle drops the pulse.
    gen_bit(1'b1);
    check_out("flip1", 1'b1, 1'b1, 1);
    send(1'b0, 1'b0);
    check_out("flip1.idle", 1'b1, 1'b0, 1);
    for (int i = 0; i < 10; i++) begin
      gen_bit(1'b0);
      check_out("flip1.after", 1'b1, 1'b0, 1);
    end

    // Clear alone, with no valid bit.
    clear_i = 1'b1;
    send(1'b0, 1'b0);
    clear_i = 1'b0;
    check_out("clear", 1'b1, 1'b0, 0);

    // Three consecutive errors lose lock on the third; count keeps the third.
    gen_bit(1'b1);
    check_out("loss1", 1'b1, 1'b1, 1);
    gen_bit(1'b1);
    check_out("loss2", 1'b1, 1'b1, 2);
    gen_bit(1'b1);
    check_out("loss3", 1'b0, 1'b1, 3);
    for (int i = 1; i <= 12; i++) begin
      gen_bit(1'b0);
      check_out("relock", i >= 12, 1'b0, 3);
    end

    // Clear together with an error: clear wins, pulse still fires.
    clear_i = 1'b1;
    gen_bit(1'b1);
    clear_i = 1'b0;
    check_out("clear_err", 1'b1, 1'b1, 0);
    gen_bit(1'b0);
    check_out("clear_err.next", 1'b1, 1'b0, 0);

    // 20 isolated errors: count saturates at 15 without losing lock.
    for (int k = 1; k <= 20; k++) begin
      gen_bit(1'b1);
      check_out("sat", 1'b1, 1'b1, (k > 15) ? 15 : k);
      gen_bit(1'b0);
      check_out("sat.clean", 1'b1, 1'b0, (k > 15) ? 15 : k);
    end

    // Asynchronous reset mid-lock while err_o is high.
    clear_i = 1'b1;
    send(1'b0, 1'b0);
    clear_i = 1'b0;
    gen_bit(1'b1);
    check_out("pre_reset", 1'b1, 1'b1, 1);
    #1;
    reset = 1'b0;
    #1;
    check_out("async_reset", 1'b0, 1'b0, 0);
    @(negedge clk);
    reset = 1'b1;

    // Constant-zero data never locks.
    for (int i = 0; i < 50; i++) begin
      send(1'b1, 1'b0);
      check_out("zeros", 1'b0, 1'b0, 0);
    end

    // Fresh start, clean stream at ~50% valid duty; idle cycles change nothing.
    reset = 1'b0;
    #2;
    reset = 1'b1;
    begin
      int nvalid;
      int ncyc;
      nvalid = 0;
      ncyc   = 0;
      while (nvalid < 16 && ncyc < 500) begin
        if ($urandom_range(0, 1) == 1) begin
          gen_bit(1'b0);
          nvalid++;
        end else begin
          send(1'b0, 1'($urandom_range(0, 1)));
        end
        ncyc++;
        check_out("duty", nvalid >= 12, 1'b0, 0);
      end
      check("duty.budget", 32'(nvalid), 16);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prbs4_checker.md
# prbs4_checker

Serial PRBS-4 checker that is the receive end of the 4-bit LFSR pattern generator (`q_o[3:0]`). It takes the generator's serial bit stream one bit per valid cycle and self-synchronises to the x^4+x^3+1 sequence. It then reports lock status, per-bit error pulses and a saturating error count. It is used on the bench and in loopback paths to qualify the generator and any serial link placed between generator and checker.

## Interface
- LOCK_CNT, 8, consecutive correctly predicted bits required to declare lock (1..15)
- LOSS_CNT, 3, consecutive mismatches while locked that drop lock (1..15)
- CNT_W, 8, width of error counter

Ports:
- clk  in  1  rising-edge clock, the only clock
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately
- valid_i  in  1  data_i carries a stream bit this cycle
- data_i  in  1  received serial bit
- clear_i  in  1  synchronous clear of err_cnt_o
- locked_o  out  1  checker is in LOCKED state
- err_o  out  1  one-cycle pulse: the previous valid bit mismatched while locked
- err_cnt_o  out  CNT_W  saturating count of mismatches while locked

## Operation
- Sequence convention matches the generator:
  - history h[3:0], with h[0] the newest bit
  - predicted bit p = h[3] ^ h[2]
  - every accepted bit shifts in as h <= {h[2:0], bit}
- Only cycles with valid_i=1 advance any state. Cycles with valid_i=0 hold everything, and err_o is 0 on them.
- States: SEARCH (reset state) and LOCKED.
- SEARCH:
  - h shifts in data_i.
  - A 3-bit fill counter counts the first 4 valid bits, saturating at 4. No comparison is made until fill=4.
  - Once fill=4, each valid bit compares data_i with p:
    - match with h≠0: match_cnt+1
    - mismatch, or h==0: match_cnt cleared to 0. The all-zero lock-up pattern never qualifies.
  - When a valid bit takes match_cnt to LOCK_CNT, the state goes to LOCKED on that clock edge.
  - err_o and err_cnt_o are never updated in SEARCH.
- LOCKED:
  - h shifts in p, not data_i; the local LFSR is free-running on valid.
  - Each valid bit compares data_i with p:
    - mismatch: err_o=1 the next cycle, err_cnt_o+1 (saturating at 2^CNT_W−1), miss_cnt+1
    - match: miss_cnt cleared to 0
  - When miss_cnt reaches LOSS_CNT, the state goes to SEARCH on that edge, and fill, match_cnt and miss_cnt are cleared.
  - The error that causes loss still pulses err_o and increments err_cnt_o.
- clear_i versus errors:
  - clear_i=1 forces err_cnt_o to 0 on the next edge and wins over a simultaneous increment.
  - clear_i does not affect state, err_o, or the other counters.
- Widths: match_cnt and miss_cnt are 4 bits. err_cnt_o saturates and never wraps.

## Timing
- Reset values (asynchronous, while reset=0):
  - locked_o=0, err_o=0, err_cnt_o=0
  - state=SEARCH, h=0, fill=0, match_cnt=0, miss_cnt=0
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency from a valid bit to its result:
  - err_o rises in the cycle after the clock edge that sampled the bad bit and stays high for exactly one cycle.
  - err_cnt_o updates on that same edge.
  - locked_o changes on the edge that samples the deciding bit, in both directions.
- Minimum lock time from reset with a clean stream: 4 + LOCK_CNT valid bits (12 with defaults).
- Reset asserted mid-operation:
  - all state clears at once, with no clock needed
  - after release, the checker restarts in SEARCH and needs the full fill + lock sequence again
- Back-to-back valid bits every cycle are supported at full rate.

## Test plan
- Reset, then 20 idle cycles -> locked_o=0, err_o=0, err_cnt_o=0 throughout.
- Generator seeded with 4'b0001 drives valid_i=1 every cycle -> locked_o rises on the 12th valid bit; err_cnt_o stays 0 over 100 bits.
- Locked; invert one bit -> err_o single pulse on the next cycle, err_cnt_o=1, locked_o stays 1, following bits produce no errors.
- Locked; invert 3 consecutive bits -> err_cnt_o=3 and locked_o falls after the 3rd bit. Clean stream resumes -> relock after 12 more valid bits, err_cnt_o holds at 3.
- Stimulus sweep:
  - data_i held at 0 for 50 valid bits -> never locks
  - a random valid_i duty cycle of about 50% with a clean stream -> locks after 12 valid bits; idle cycles change nothing
- CNT_W=4; force 20 errors by repeated lock/flip cycles -> err_cnt_o saturates at 15.
  - clear_i pulsed together with an error -> err_cnt_o=0.
  - reset pulsed low mid-lock -> all outputs 0 immediately.
